// File: rtl/rf_pkg.sv
// Shared register-file write types and widths for the writeback arbiter slice.
package rf_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned XLEN       = 32;
   localparam int unsigned NUM_REGS   = 32;

   typedef struct packed {
      logic                  we;
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } rf_wr_t;

   // Long-unit result as held in the FIFO (always a write, so no enable bit).
   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } rf_ent_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Circular FIFO of long-unit results; pointers carry one extra wrap bit so
// full and empty are distinguished without a separate counter.
module rf_wb_fifo
   import rf_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  rf_ent_t                push_ent,
   input  logic                   pop,
   output rf_ent_t                head,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   rf_ent_t          mem_q [DEPTH];
   rf_ent_t          mem_d [DEPTH];

   assign level = wr_ptr_q - rd_ptr_q;
   assign full  = (level == PTR_W'(DEPTH));
   assign empty = (level == '0);
   assign head  = mem_q[rd_ptr_q[IDX_W-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      mem_d    = mem_q;
      if (push) begin
         mem_d[wr_ptr_q[IDX_W-1:0]] = push_ent;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: reset empties the FIFO through the pointers.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and
// buffered long-unit results, and tracks outstanding long writes per register.
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pipe_we,
   input  logic [REG_ADDR_W-1:0]  pipe_addr,
   input  logic [XLEN-1:0]        pipe_data,
   output logic                   stall_pipe,
   input  logic                   lu_issue,
   input  logic [REG_ADDR_W-1:0]  lu_issue_addr,
   input  logic                   lu_valid,
   output logic                   lu_ready,
   input  logic [REG_ADDR_W-1:0]  lu_addr,
   input  logic [XLEN-1:0]        lu_data,
   output logic                   rf_we,
   output logic [REG_ADDR_W-1:0]  rf_addr,
   output logic [XLEN-1:0]        rf_data,
   output logic [NUM_REGS-1:0]    busy_mask,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic                   err_multi
);

   localparam int unsigned CNT_W = $clog2(MAX_WAIT) + 1;

   logic                  fifo_full, fifo_empty;
   logic                  push_c, pop_c;
   rf_ent_t               head, push_ent;
   rf_wr_t                gnt_c;

   logic                  stall_pipe_q, stall_pipe_d;
   logic [CNT_W-1:0]      starve_q, starve_d;
   logic                  rf_we_q, rf_we_d;
   logic [REG_ADDR_W-1:0] rf_addr_q, rf_addr_d;
   logic [XLEN-1:0]       rf_data_q, rf_data_d;
   logic [NUM_REGS-1:0]   busy_q, busy_d;
   logic                  err_q, err_d;

   assign lu_ready = !fifo_full;
   assign push_c   = lu_valid && !fifo_full;
   assign push_ent = '{addr: lu_addr, data: lu_data};

   rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push_c),
      .push_ent (push_ent),
      .pop      (pop_c),
      .head     (head),
      .level    (fifo_level),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Grant selection: a starvation stall forces the FIFO head, else pipeline first.
   always_comb begin
      gnt_c = '0;
      pop_c = 1'b0;
      if (stall_pipe_q && !fifo_empty) begin
         pop_c = 1'b1;
         gnt_c = '{we: 1'b1, addr: head.addr, data: head.data};
      end else if (pipe_we && !stall_pipe_q) begin
         gnt_c = '{we: 1'b1, addr: pipe_addr, data: pipe_data};
      end else if (!fifo_empty) begin
         pop_c = 1'b1;
         gnt_c = '{we: 1'b1, addr: head.addr, data: head.data};
      end
   end

   always_comb begin
      // r0 is hardwired zero: the grant is consumed but nothing reaches the RF.
      rf_we_d   = gnt_c.we && (gnt_c.addr != '0);
      rf_addr_d = rf_we_d ? gnt_c.addr : rf_addr_q;
      rf_data_d = rf_we_d ? gnt_c.data : rf_data_q;

      stall_pipe_d = 1'b0;
      starve_d     = starve_q;
      if (fifo_empty || pop_c) begin
         starve_d = '0;
      end else if (starve_q == CNT_W'(MAX_WAIT - 1)) begin
         starve_d     = '0;
         stall_pipe_d = 1'b1;
      end else begin
         starve_d = starve_q + CNT_W'(1);
      end

      // Set after clear so a same-cycle reissue keeps the register busy.
      busy_d = busy_q;
      if (pop_c) begin
         busy_d[head.addr] = 1'b0;
      end
      if (lu_issue && (lu_issue_addr != '0)) begin
         busy_d[lu_issue_addr] = 1'b1;
      end
      err_d = err_q || (lu_issue && busy_q[lu_issue_addr]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_pipe_q <= 1'b0;
         starve_q     <= '0;
         rf_we_q      <= 1'b0;
         rf_addr_q    <= '0;
         rf_data_q    <= '0;
         busy_q       <= '0;
         err_q        <= 1'b0;
      end else begin
         stall_pipe_q <= stall_pipe_d;
         starve_q     <= starve_d;
         rf_we_q      <= rf_we_d;
         rf_addr_q    <= rf_addr_d;
         rf_data_q    <= rf_data_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
      end
   end

   assign stall_pipe = stall_pipe_q;
   assign rf_we      = rf_we_q;
   assign rf_addr    = rf_addr_q;
   assign rf_data    = rf_data_q;
   assign busy_mask  = busy_q;
   assign err_multi  = err_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter (DEPTH=2, MAX_WAIT=4) with hand-computed expectations.
module tb_rf_write_arbiter;

   logic        clk;
   logic        rst;
   logic        pipe_we;
   logic [4:0]  pipe_addr;
   logic [31:0] pipe_data;
   logic        stall_pipe;
   logic        lu_issue;
   logic [4:0]  lu_issue_addr;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_addr;
   logic [31:0] lu_data;
   logic        rf_we;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic [31:0] busy_mask;
   logic [1:0]  fifo_level;
   logic        err_multi;

   int n_checks = 0;
   int n_fail   = 0;

   rf_write_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .pipe_we       (pipe_we),
      .pipe_addr     (pipe_addr),
      .pipe_data     (pipe_data),
      .stall_pipe    (stall_pipe),
      .lu_issue      (lu_issue),
      .lu_issue_addr (lu_issue_addr),
      .lu_valid      (lu_valid),
      .lu_ready      (lu_ready),
      .lu_addr       (lu_addr),
      .lu_data       (lu_data),
      .rf_we         (rf_we),
      .rf_addr       (rf_addr),
      .rf_data       (rf_data),
      .busy_mask     (busy_mask),
      .fifo_level    (fifo_level),
      .err_multi     (err_multi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
      chk({tag, ".we"}, 32'(rf_we), 32'(we));
      chk({tag, ".addr"}, 32'(rf_addr), 32'(a));
      chk({tag, ".data"}, rf_data, d);
   endtask

   initial begin
      rst = 1'b1; pipe_we = 1'b0; pipe_addr = '0; pipe_data = '0;
      lu_issue = 1'b0; lu_issue_addr = '0; lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
      tick(); tick();
      rst = 1'b0;
      tick();

      // Reset / idle state
      chk_rf("idle", 1'b0, 5'd0, 32'h0);
      chk("idle.busy", busy_mask, 32'h0);
      chk("idle.ready", 32'(lu_ready), 32'd1);
      chk("idle.level", 32'(fifo_level), 32'd0);
      chk("idle.stall", 32'(stall_pipe), 32'd0);
      chk("idle.err", 32'(err_multi), 32'd0);

      // Pipeline write, then a write to r0 that must be suppressed
      pipe_we = 1'b1; pipe_addr = 5'd5; pipe_data = 32'hDEADBEEF;
      tick();
      chk_rf("pipe5", 1'b1, 5'd5, 32'hDEADBEEF);
      pipe_addr = 5'd0; pipe_data = 32'h55;
      tick();
      chk_rf("pipe0", 1'b0, 5'd5, 32'hDEADBEEF);
      pipe_we = 1'b0;
      tick();
      chk("pipe_idle.we", 32'(rf_we), 32'd0);

      // Issue to r9, return result with pipeline idle
      lu_issue = 1'b1; lu_issue_addr = 5'd9;
      tick();
      lu_issue = 1'b0;
      chk("issue9.busy", busy_mask, 32'h200);
      lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h1234;
      tick();
      lu_valid = 1'b0;
      chk("push9.level", 32'(fifo_level), 32'd1);
      chk("push9.we", 32'(rf_we), 32'd0);
      chk("push9.busy", busy_mask, 32'h200);
      tick();
      chk_rf("pop9", 1'b1, 5'd9, 32'h1234);
      chk("pop9.busy", busy_mask, 32'h0);
      chk("pop9.level", 32'(fifo_level), 32'd0);
      tick();
      chk("after9.we", 32'(rf_we), 32'd0);

      // Starvation: head r3 waits behind a continuous pipeline stream
      lu_issue = 1'b1; lu_issue_addr = 5'd3;
      tick();
      lu_issue = 1'b0;
      chk("issue3.busy", busy_mask, 32'h8);
      pipe_we = 1'b1; pipe_addr = 5'd10; pipe_data = 32'h111;
      lu_valid = 1'b1; lu_addr = 5'd3; lu_data = 32'hA5A5;
      tick();
      lu_valid = 1'b0;
      chk("starve0.level", 32'(fifo_level), 32'd1);
      chk_rf("starve0", 1'b1, 5'd10, 32'h111);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk($sformatf("starve%0d.stall", i), 32'(stall_pipe), 32'd0);
         chk($sformatf("starve%0d.addr", i), 32'(rf_addr), 32'd10);
      end
      tick();
      chk("starve4.stall", 32'(stall_pipe), 32'd1);
      chk("starve4.level", 32'(fifo_level), 32'd1);
      tick();
      chk_rf("stall_pop", 1'b1, 5'd3, 32'hA5A5);
      chk("stall_pop.stall", 32'(stall_pipe), 32'd0);
      chk("stall_pop.busy", busy_mask, 32'h0);
      chk("stall_pop.level", 32'(fifo_level), 32'd0);
      tick();
      chk_rf("held_pipe", 1'b1, 5'd10, 32'h111);

      // Fill the FIFO while the pipeline hogs the port
      pipe_addr = 5'd11; pipe_data = 32'h222;
      lu_valid = 1'b1; lu_addr = 5'd12; lu_data = 32'hC1;
      tick();
      chk("fill1.level", 32'(fifo_level), 32'd1);
      chk("fill1.ready", 32'(lu_ready), 32'd1);
      lu_addr = 5'd13; lu_data = 32'hC2;
      tick();
      chk("fill2.level", 32'(fifo_level), 32'd2);
      chk("fill2.ready", 32'(lu_ready), 32'd0);
      lu_addr = 5'd14; lu_data = 32'hC3;
      tick();
      chk("full_hold.level", 32'(fifo_level), 32'd2);
      chk("full_hold.ready", 32'(lu_ready), 32'd0);
      chk("full_hold.stall", 32'(stall_pipe), 32'd0);
      tick();
      chk("full_d.stall", 32'(stall_pipe), 32'd0);
      tick();
      chk("full_e.stall", 32'(stall_pipe), 32'd1);
      chk("full_e.ready", 32'(lu_ready), 32'd0);
      tick();
      chk_rf("full_pop", 1'b1, 5'd12, 32'hC1);
      chk("full_pop.level", 32'(fifo_level), 32'd1);
      chk("full_pop.ready", 32'(lu_ready), 32'd1);
      tick();
      chk_rf("full_pipe", 1'b1, 5'd11, 32'h222);
      chk("full_pipe.level", 32'(fifo_level), 32'd2);
      lu_valid = 1'b0; pipe_we = 1'b0;
      tick();
      chk_rf("drain13", 1'b1, 5'd13, 32'hC2);
      tick();
      chk_rf("drain14", 1'b1, 5'd14, 32'hC3);
      chk("drain14.level", 32'(fifo_level), 32'd0);
      tick();
      chk("drained.we", 32'(rf_we), 32'd0);

      // Double issue to r7 is sticky until reset
      lu_issue = 1'b1; lu_issue_addr = 5'd7;
      tick();
      chk("issue7a.busy", busy_mask, 32'h80);
      chk("issue7a.err", 32'(err_multi), 32'd0);
      tick();
      lu_issue = 1'b0;
      chk("issue7b.err", 32'(err_multi), 32'd1);
      chk("issue7b.busy", busy_mask, 32'h80);
      pipe_we = 1'b1; pipe_addr = 5'd20; pipe_data = 32'h333;
      lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'h77;
      tick();
      lu_valid = 1'b0;
      chk("sticky.err", 32'(err_multi), 32'd1);
      chk("pre_rst.level", 32'(fifo_level), 32'd1);

      // Reset mid-occupancy discards everything
      rst = 1'b1;
      tick();
      chk("rst.level", 32'(fifo_level), 32'd0);
      chk("rst.busy", busy_mask, 32'h0);
      chk("rst.err", 32'(err_multi), 32'd0);
      chk_rf("rst", 1'b0, 5'd0, 32'h0);
      rst = 1'b0; pipe_we = 1'b0;
      tick();
      chk("post_rst.we", 32'(rf_we), 32'd0);
      chk("post_rst.level", 32'(fifo_level), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback stage and a long-latency unit (mul/div) that returns results out of band.
- Buffers long-unit results in a small FIFO and grants the pipeline priority, with a starvation guard that stalls the pipeline for one cycle.
- Keeps a per-register pending-write scoreboard that the hazard unit reads.
- Drives the register file's write_enabled/write_addr/write_data inputs directly; the register file does not protect $zero, so this block does.

Parameters:
- DEPTH, 2, long-unit result FIFO entries (power of 2, >=2)
- MAX_WAIT, 4, cycles a non-empty FIFO head may go ungranted before stall_pipe fires (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pipe_we  in  1  pipeline writeback request
- pipe_addr  in  5  pipeline destination register
- pipe_data  in  32  pipeline result
- stall_pipe  out  1  pipeline must hold WB this cycle; pipe_we ignored
- lu_issue  in  1  long op issued this cycle
- lu_issue_addr  in  5  destination of issued long op
- lu_valid  in  1  long-unit result valid
- lu_ready  out  1  FIFO can accept (= !full)
- lu_addr  in  5  long-unit result destination
- lu_data  in  32  long-unit result
- rf_we  out  1  to register file write_enabled
- rf_addr  out  5  to register file write_addr
- rf_data  out  32  to register file write_data
- busy_mask  out  32  bit i = long write to register i outstanding
- fifo_level  out  $clog2(DEPTH)+1  FIFO occupancy
- err_multi  out  1  sticky: lu_issue to an already-busy register

Behaviour:
- Reset: FIFO emptied (in-flight contents discarded), starve counter 0, stall_pipe 0, rf_we 0, rf_addr 0, rf_data 0, busy_mask 0, err_multi 0. Reset dominates every other event in the same cycle.
- Push: lu_valid && lu_ready. lu_ready is combinational !full. A full FIFO has no bypass.
- Grant, evaluated each cycle, in priority order:
  1. stall_pipe=1 and FIFO non-empty -> pop head.
  2. pipe_we && !stall_pipe -> pipeline.
  3. FIFO non-empty -> pop head.
- Output timing: the grant is registered. rf_we/rf_addr/rf_data are valid the cycle after the grant. The register file then commits on the following edge.
- $zero: a grant whose addr==0 drives rf_we=0 and data is dropped. A FIFO head to r0 is still popped. A pipeline write to r0 is absorbed, not retried.
- No grant: rf_we=0; rf_addr and rf_data hold their last values.
- Push and pop in the same cycle on a non-full FIFO: both happen, level unchanged. Push to an empty FIFO becomes head next cycle (no same-cycle grant).
- Starve counter:
  - +1 each cycle the FIFO is non-empty and the head is not popped.
  - Cleared on a pop or when the FIFO is empty.
  - When counter==MAX_WAIT-1 and the head is not popped, stall_pipe=1 next cycle for exactly one cycle; counter clears.
- Scoreboard:
  - lu_issue with addr!=0 sets busy_mask[addr].
  - A FIFO pop clears busy_mask[head addr].
  - Set and clear of the same bit in one cycle: set wins.
  - lu_issue to an already-busy bit sets err_multi (sticky until rst); the bit stays set.
- Hazards: WAW/RAW against busy registers are the hazard unit's responsibility. Pipeline writes to busy registers are granted unchanged.
- fifo_level and busy_mask are registered state, visible the cycle after the update.

Decomposition:
- Shared package rf_pkg holds:
  - REG_ADDR_W=5, XLEN=32, NUM_REGS=32
  - typedef rf_wr_t {logic we; logic [4:0] addr; logic [31:0] data;}
- One sub-module, rf_wb_fifo: a DEPTH-entry circular FIFO of {addr,data} with wrap-around pointers plus an extra level bit. The scoreboard and arbitration stay in the top module.

Test Plan:
- Reset, then idle -> rf_we=0, busy_mask=0, lu_ready=1, fifo_level=0.
- pipe_we=1, pipe_addr=5, pipe_data=0xDEADBEEF for one cycle -> next cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF. Same with pipe_addr=0 -> rf_we stays 0.
- lu_issue addr=9 -> busy_mask=0x200. Next, lu_valid addr=9, data=0x1234 with pipe idle -> popped next cycle, rf_we=1, rf_addr=9, then busy_mask=0.
- MAX_WAIT=4: FIFO holds addr=3 while pipe_we=1 every cycle -> stall_pipe=1 on the 5th cycle after the push, FIFO entry written (rf_addr=3) the cycle after, and the pipeline write held during stall appears next.
- DEPTH=2: push two results while pipe_we=1 continuously -> lu_ready=0, a third lu_valid is not accepted and is held by the source; after a pop, lu_ready=1.
- lu_issue addr=7 twice without completion -> err_multi=1 and stays 1; assert rst mid-FIFO-occupancy -> fifo_level=0, busy_mask=0, err_multi=0 next cycle.
